// File: rtl/complex_vec_result_writer_pkg.sv
// Shared constants, FSM encoding and sizing helpers for complex_vec_result_writer.
package complex_vec_result_writer_pkg;

  localparam int unsigned ELEMENT_WIDTH = 64;
  localparam int unsigned NI            = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  // Lane j maps to mask bit ni-1-j, so the valid lanes of the final beat sit at the top.
  function automatic logic [63:0] last_lane_mask(input int unsigned noe, input int unsigned ni);
    int unsigned lanes;
    logic [63:0] m;
    lanes = noe - (ceil_div(noe, ni) - 1) * ni;
    m = '0;
    for (int unsigned i = 0; i < lanes; i++) begin
      m = m | (64'd1 << (ni - 1 - i));
    end
    return m;
  endfunction

endpackage

// File: rtl/complex_vec_result_writer_valid_delay_line.sv
// LATENCY-deep 1-bit shift register tracking issued beats through the datapath.
module valid_delay_line
  import complex_vec_result_writer_pkg::*;
#(
  parameter int unsigned LATENCY = 12
) (
  input  logic clk,
  input  logic clear,
  input  logic din,
  output logic dout
);

  logic [LATENCY-1:0] pipe;

  always_ff @(posedge clk) begin
    if (clear) begin
      pipe <= '0;
    end else begin
      pipe <= (pipe << 1) | LATENCY'(din);
    end
  end

  assign dout = pipe[LATENCY-1];

endmodule

// File: rtl/complex_vec_result_writer.sv
// Realigns issued beats with the datapath result bus and writes them to vector RAM.
// Optional macro COMPLEX_WR_ZERO_PAD_EN: zero padding lanes of the last beat and write all lanes.
module complex_vec_result_writer #(
  parameter int unsigned NOE           = 19,
  parameter int unsigned NI            = complex_vec_result_writer_pkg::NI,
  parameter int unsigned ELEMENT_WIDTH = complex_vec_result_writer_pkg::ELEMENT_WIDTH,
  parameter int unsigned LATENCY       = 12,
  parameter int unsigned ADDR_W        = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic                        in_valid,
  input  logic [ELEMENT_WIDTH*NI-1:0] result_in,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [ELEMENT_WIDTH*NI-1:0] wr_data,
  output logic [NI-1:0]               wr_lane_mask,
  output logic                        busy,
  output logic                        finish,
  output logic                        overrun
);
  import complex_vec_result_writer_pkg::*;

  localparam int unsigned       BEATS     = ceil_div(NOE, NI);
  localparam int unsigned       CNT_W     = $clog2(BEATS + 1);
  localparam logic [NI-1:0]     LAST_MASK = NI'(last_lane_mask(NOE, NI));
  localparam logic [CNT_W-1:0]  BEATS_C   = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(BEATS - 1);

  state_t                      state, state_next;
  logic [CNT_W-1:0]            issue_cnt, wr_cnt;
  logic [ADDR_W-1:0]           base_q;
  logic                        accept, issue, tail, last_write;
  logic [NI-1:0]               lane_mask, mask_out;
  logic [ELEMENT_WIDTH*NI-1:0] data_out;

  assign accept     = start && (state != RUN);
  // Counters are cleared on accept, so a beat on the accept cycle is always in range.
  assign issue      = in_valid && (accept || ((state == RUN) && (issue_cnt < BEATS_C)));
  assign last_write = (state == RUN) && wr_en && (wr_cnt == BEATS_C);
  assign busy       = (state == RUN);

  valid_delay_line #(
    .LATENCY(LATENCY)
  ) u_delay (
    .clk  (clk),
    .clear(reset),
    .din  (issue),
    .dout (tail)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = RUN;
      RUN:        if (last_write) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt <= '0;
      wr_cnt    <= '0;
      base_q    <= '0;
      finish    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept) begin
        issue_cnt <= issue ? CNT_W'(1) : '0;
        wr_cnt    <= '0;
        base_q    <= base_addr;
        finish    <= 1'b0;
      end else begin
        if (issue)      issue_cnt <= issue_cnt + 1'b1;
        if (tail)       wr_cnt    <= wr_cnt + 1'b1;
        if (last_write) finish    <= 1'b1;
      end
      if (in_valid && !issue) overrun <= 1'b1;
    end
  end

  assign lane_mask = (wr_cnt == LAST_IDX) ? LAST_MASK : '1;

  always_comb begin
    data_out = result_in;
    mask_out = lane_mask;
`ifdef COMPLEX_WR_ZERO_PAD_EN
    for (int unsigned k = 0; k < NI; k++) begin
      if (!lane_mask[k]) data_out[k*ELEMENT_WIDTH +: ELEMENT_WIDTH] = '0;
    end
    mask_out = '1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_lane_mask <= '0;
    end else begin
      wr_en <= tail;
      if (tail) begin
        wr_addr      <= base_q + ADDR_W'(wr_cnt);
        wr_data      <= data_out;
        wr_lane_mask <= mask_out;
      end
    end
  end

endmodule

// File: tb/tb_complex_vec_result_writer.sv
// Scoreboard bench for complex_vec_result_writer; honours COMPLEX_WR_ZERO_PAD_EN when defined.
module tb_complex_vec_result_writer;
  localparam int NOE   = 19;
  localparam int NI    = 8;
  localparam int EW    = 64;
  localparam int LAT   = 12;
  localparam int AW    = 8;
  localparam int BEATS = (NOE + NI - 1) / NI;
  localparam int LAST  = NOE - (BEATS - 1) * NI;
  localparam int DEPTH = 8192;

  logic            clk = 1'b0;
  logic            reset = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [EW*NI-1:0] result_in = '0;
  logic            wr_en, busy, finish, overrun;
  logic [AW-1:0]   wr_addr;
  logic [EW*NI-1:0] wr_data;
  logic [NI-1:0]   wr_lane_mask;

  always #5 clk = ~clk;

  complex_vec_result_writer #(
    .NOE(NOE), .NI(NI), .ELEMENT_WIDTH(EW), .LATENCY(LAT), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .result_in(result_in), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_lane_mask(wr_lane_mask), .busy(busy), .finish(finish),
    .overrun(overrun)
  );

  typedef struct {
    int               cyc;
    logic [AW-1:0]    addr;
    logic [NI-1:0]    mask;
    logic [EW*NI-1:0] data;
  } exp_t;

  exp_t             sb[$];
  logic [EW*NI-1:0] res_mem [DEPTH];
  int               cyc = 0;
  int               total = 0, bad = 0;
  bit               chk_en = 1'b0;
  bit               m_active = 0, m_finished = 0, m_ovr = 0;
  int               m_issued = 0, m_last_wr = 0;
  logic [AW-1:0]    m_base = '0;
  logic             exp_busy = 0, exp_finish = 0, exp_ovr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t make_exp(input int k, input int c);
    exp_t e;
    int   lanes;
    e.cyc  = c + LAT + 1;
    e.addr = m_base + AW'(k);
    e.data = res_mem[(c + LAT) % DEPTH];
    e.mask = '0;
    lanes  = (k < BEATS - 1) ? NI : LAST;
    for (int j = 0; j < NI; j++) begin
      if (j < lanes) e.mask[NI-1-j] = 1'b1;
`ifdef COMPLEX_WR_ZERO_PAD_EN
      else e.data[EW*(NI-j)-1 -: EW] = '0;
`endif
    end
`ifdef COMPLEX_WR_ZERO_PAD_EN
    e.mask = '1;
`endif
    return e;
  endfunction

  // One cycle of stimulus; expected flags are those visible before this cycle's inputs act.
  task automatic step(input bit rs, input bit st, input bit iv, input logic [AW-1:0] ba);
    @(posedge clk);
    #1;
    if (m_active && m_issued == BEATS && cyc > m_last_wr) begin
      m_active   = 0;
      m_finished = 1;
    end
    exp_busy   = m_active;
    exp_finish = m_finished;
    exp_ovr    = m_ovr;
    reset      = rs;
    start      = st;
    in_valid   = iv;
    base_addr  = ba;
    result_in  = res_mem[cyc % DEPTH];
    if (rs) begin
      m_active   = 0;
      m_finished = 0;
      m_ovr      = 0;
      while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
    end else begin
      if (st && !m_active) begin
        m_active   = 1;
        m_finished = 0;
        m_issued   = 0;
        m_base     = ba;
      end
      if (iv) begin
        if (m_active && m_issued < BEATS) begin
          sb.push_back(make_exp(m_issued, cyc));
          if (m_issued == BEATS - 1) m_last_wr = cyc + LAT + 1;
          m_issued++;
        end else begin
          m_ovr = 1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      total++;
      if ({busy, finish, overrun} !== {exp_busy, exp_finish, exp_ovr}) begin
        bad++;
        $display("FAIL flags cyc=%0d busy/finish/overrun got=%b%b%b want=%b%b%b",
                 cyc, busy, finish, overrun, exp_busy, exp_finish, exp_ovr);
      end
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_write cyc=%0d got=none want_cyc=%0d", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (wr_en === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write cyc=%0d got addr=%h want=no write", cyc, wr_addr);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || wr_addr !== e.addr || wr_lane_mask !== e.mask || wr_data !== e.data) begin
            bad++;
            $display("FAIL write got cyc=%0d addr=%h mask=%h want cyc=%0d addr=%h mask=%h",
                     cyc, wr_addr, wr_lane_mask, e.cyc, e.addr, e.mask);
            $display("FAIL write_data got=%h want=%h", wr_data, e.data);
          end
        end
      end else begin
        if (wr_en !== 1'b0) begin
          total++;
          bad++;
          $display("FAIL wr_en_x cyc=%0d got=%b want=0", cyc, wr_en);
        end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
          total++;
          bad++;
          $display("FAIL missing_write cyc=%0d got=none want addr=%h", cyc, sb[0].addr);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout got=no finish want=finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++)
      for (int w = 0; w < 2 * NI; w++)
        res_mem[i][w*32 +: 32] = $urandom();

    repeat (3) step(1, 0, 0, '0);
    chk_en = 1'b1;

    // back-to-back beats, base 0x10
    step(0, 1, 0, 8'h10);
    repeat (3) step(0, 0, 1, '0);
    repeat (LAT + 6) step(0, 0, 0, '0);

    // gap in issue: beats 1, 4, 5 after start
    step(0, 1, 0, 8'h40);
    step(0, 0, 1, '0);
    repeat (2) step(0, 0, 0, '0);
    repeat (2) step(0, 0, 1, '0);
    repeat (LAT + 6) step(0, 0, 0, '0);

    // fourth beat overruns
    step(0, 1, 0, 8'h20);
    repeat (4) step(0, 0, 1, '0);
    repeat (LAT + 6) step(0, 0, 0, '0);
    step(1, 0, 0, '0);

    // address wrap from 0xFF
    step(0, 1, 0, 8'hFF);
    repeat (3) step(0, 0, 1, '0);
    repeat (LAT + 6) step(0, 0, 0, '0);

    // reset with beats in flight
    step(0, 1, 0, 8'h30);
    repeat (3) step(0, 0, 1, '0);
    repeat (3) step(0, 0, 0, '0);
    step(1, 0, 0, '0);
    repeat (LAT + 6) step(0, 0, 0, '0);

    // randomized operations: gaps, beat on start cycle, ignored starts, overruns, resets
    for (int n = 0; n < 60; n++) begin
      step(0, 1, 1'($urandom_range(0, 1)), 8'($urandom()));
      for (int i = 0; i < 10; i++) begin
        if ($urandom_range(0, 24) == 0) step(1, 0, 0, '0);
        else step(0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, 8'($urandom()));
      end
      repeat ($urandom_range(LAT + 2, LAT + 6)) step(0, 0, $urandom_range(0, 19) == 0, '0);
      if ($urandom_range(0, 2) == 0) step(1, 0, 0, '0);
    end

    repeat (LAT + 6) step(0, 0, 0, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
